// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped front end for a UART transmitter/receiver pair.
// CPU writes are queued in a TX FIFO and fed to the transmitter one byte per
// busy handshake. Received bytes land in an RX FIFO. Status, control and a
// level interrupt are exposed on a small four-word register window.
module uart_mmio_ctrl #(
  parameter int PAYLOAD_BITS = 8,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             bus_addr,
  input  logic [31:0]             bus_wdata,
  input  logic                    bus_wen,
  input  logic                    bus_ren,
  output logic [31:0]             bus_rdata,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_en,
  input  logic                    tx_busy,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_break,
  output logic                    irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_t;

  tx_state_t state, state_nxt;

  // Only the word select is decoded; the upstream decoder qualifies the region.
  logic [1:0] reg_sel;
  logic       wr_acc;
  logic       rd_acc;
  logic       unused_bits;

  assign reg_sel     = bus_addr[3:2];
  assign wr_acc      = bus_wen;
  // A simultaneous write wins and the read side effect is suppressed.
  assign rd_acc      = bus_ren & ~bus_wen;
  assign unused_bits = ^{bus_addr[63:4], bus_addr[1:0], bus_wdata[31:8]};

  // TX FIFO
  logic [PAYLOAD_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]        tx_wptr, tx_rptr;
  logic [TX_CW-1:0]        tx_count;
  logic                    tx_full, tx_empty;
  logic                    tx_push, tx_push_ok, tx_pop;
  logic [PAYLOAD_BITS-1:0] tx_head;
  logic [PAYLOAD_BITS-1:0] tx_last;

  assign tx_full    = (tx_count == TX_FULL_CNT);
  assign tx_empty   = (tx_count == '0);
  assign tx_push    = wr_acc & (reg_sel == REG_TXDATA);
  assign tx_push_ok = tx_push & ~tx_full;
  // LAUNCH is only entered with a non-empty FIFO, so its pop is always legal.
  assign tx_pop     = (state == S_LAUNCH);
  assign tx_head    = tx_mem[tx_rptr];

  // RX FIFO
  logic [PAYLOAD_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]        rx_wptr, rx_rptr;
  logic [RX_CW-1:0]        rx_count;
  logic                    rx_full, rx_empty;
  logic                    rx_pop, rx_push_ok;
  logic [PAYLOAD_BITS-1:0] rx_head;

  assign rx_full    = (rx_count == RX_FULL_CNT);
  assign rx_empty   = (rx_count == '0);
  assign rx_pop     = rd_acc & (reg_sel == REG_RXDATA) & ~rx_empty;
  // A full FIFO still accepts a byte when the CPU frees a slot in the same cycle.
  assign rx_push_ok = rx_valid & (~rx_full | rx_pop);
  assign rx_head    = rx_mem[rx_rptr];

  // Control and sticky status
  logic rx_irq_en, tx_irq_en;
  logic rx_overrun, break_seen, tx_overflow;
  logic ctrl_wr, sticky_clr;

  assign ctrl_wr    = wr_acc & (reg_sel == REG_CTRL);
  assign sticky_clr = ctrl_wr & bus_wdata[4];

  // TX FIFO storage; payload is not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wptr] <= bus_wdata[PAYLOAD_BITS-1:0];
  end

  // TX FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push_ok) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)     tx_rptr <= tx_rptr + 1'b1;
      tx_count <= tx_count + TX_CW'(tx_push_ok) - TX_CW'(tx_pop);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wptr] <= rx_data;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push_ok) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)     rx_rptr <= rx_rptr + 1'b1;
      rx_count <= rx_count + RX_CW'(rx_push_ok) - RX_CW'(rx_pop);
    end
  end

  // Interrupt enables, written through CTRL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      rx_irq_en <= bus_wdata[0];
      tx_irq_en <= bus_wdata[1];
    end
  end

  // Sticky error flags; a new event in the clearing cycle is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_overrun  <= 1'b0;
      break_seen  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (sticky_clr) begin
        rx_overrun  <= 1'b0;
        break_seen  <= 1'b0;
        tx_overflow <= 1'b0;
      end
      if (tx_push & tx_full)              tx_overflow <= 1'b1;
      if (rx_valid & rx_full & ~rx_pop)   rx_overrun  <= 1'b1;
      if (rx_break)                       break_seen  <= 1'b1;
    end
  end

  // Level interrupt, registered from the current FIFO state
  always_ff @(posedge clk) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
  end

  // TX sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // TX sequencer next state: launch, then see busy rise and fall before the next byte
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (!tx_empty && !tx_busy) state_nxt = S_LAUNCH;
      S_LAUNCH:    state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Last launched byte, held on tx_data between launches
  always_ff @(posedge clk) begin
    if (!rst_n)         tx_last <= '0;
    else if (tx_pop)    tx_last <= tx_head;
  end

  // TX sequencer outputs
  always_comb begin
    tx_en   = 1'b0;
    tx_data = tx_last;
    if (state == S_LAUNCH) begin
      tx_en   = 1'b1;
      tx_data = tx_head;
    end
  end

  // Combinational read mux; zero whenever no read is in effect
  always_comb begin
    bus_rdata = '0;
    if (rd_acc) begin
      unique case (reg_sel)
        REG_TXDATA: bus_rdata = '0;
        REG_RXDATA: bus_rdata = rx_empty ? 32'd0 : 32'(rx_head);
        REG_STATUS: bus_rdata = {16'd0, 4'(rx_count), 4'(tx_count), 1'b0,
                                 tx_overflow, break_seen, rx_overrun,
                                 rx_full, rx_empty, tx_empty, tx_full};
        REG_CTRL:   bus_rdata = {30'd0, tx_irq_en, rx_irq_en};
        default:    bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed testbench for uart_mmio_ctrl with a simple transmitter model:
// busy rises the cycle after tx_en and stays high for 10 cycles.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_break;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_mmio_ctrl #(.PAYLOAD_BITS(8), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_rdata(bus_rdata),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_break(rx_break),
    .irq(irq)
  );

  // Transmitter model
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  assign tx_busy = (busy_cnt != 0) | force_busy;

  always @(posedge clk) begin
    if (tx_en)             busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Launch monitor
  logic [7:0] launch_data [64];
  int         launch_cyc  [64];
  logic       launch_busy [64];
  int         n_launch = 0;

  always @(negedge clk) begin
    if (tx_en && n_launch < 64) begin
      launch_data[n_launch] <= tx_data;
      launch_cyc[n_launch]  <= cyc;
      launch_busy[n_launch] <= tx_busy;
      n_launch              <= n_launch + 1;
    end
  end

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    bus_addr  = {60'd0, sel, 2'b00};
    bus_wdata = d;
    bus_wen   = 1'b1;
    @(negedge clk);
    bus_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [31:0] d);
    @(negedge clk);
    bus_addr = {60'd0, sel, 2'b00};
    bus_ren  = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_ren  = 1'b0;
  endtask

  task automatic rx_inject(input logic [7:0] d, input logic vld, input logic brk);
    @(negedge clk);
    rx_data  = d;
    rx_valid = vld;
    rx_break = brk;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_tx_quiet();
    for (int i = 0; i < 50 && tx_busy; i++) @(negedge clk);
    wait_cycles(4);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    @(negedge clk);
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    checks++;
    if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0006) begin failures++; $display("FAIL reset_status got=%h exp=00000006", d); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=00000000", d); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL txdata_read got=%h exp=00000000", d); end
  endtask

  task automatic test_tx_basic();
    logic [31:0] d;
    int base;
    base = n_launch;
    bus_write(2'd0, 32'h41);
    bus_write(2'd0, 32'h42);
    for (int i = 0; i < 100 && n_launch < base + 2; i++) @(negedge clk);
    wait_tx_quiet();
    checks++;
    if (n_launch !== base + 2) begin failures++; $display("FAIL tx_basic_count got=%0d exp=%0d", n_launch - base, 2); end
    if (n_launch >= base + 2) begin
      checks++;
      if (launch_data[base] !== 8'h41) begin failures++; $display("FAIL tx_basic_byte0 got=%h exp=41", launch_data[base]); end
      checks++;
      if (launch_data[base+1] !== 8'h42) begin failures++; $display("FAIL tx_basic_byte1 got=%h exp=42", launch_data[base+1]); end
      checks++;
      if (launch_cyc[base+1] - launch_cyc[base] < 13) begin
        failures++; $display("FAIL tx_basic_spacing got=%0d exp>=13", launch_cyc[base+1] - launch_cyc[base]);
      end
      checks++;
      if (launch_busy[base+1] !== 1'b0) begin failures++; $display("FAIL tx_basic_busy_at_launch got=%b exp=0", launch_busy[base+1]); end
    end
    checks++;
    if (tx_data !== 8'h42) begin failures++; $display("FAIL tx_basic_hold got=%h exp=42", tx_data); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0006) begin failures++; $display("FAIL tx_basic_status got=%h exp=00000006", d); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    int base;
    base = n_launch;
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h60 + i);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0845) begin failures++; $display("FAIL tx_ovf_status got=%h exp=00000845", d); end
    checks++;
    if (n_launch !== base) begin failures++; $display("FAIL tx_ovf_launch_while_busy got=%0d exp=0", n_launch - base); end
    force_busy = 1'b0;
    for (int i = 0; i < 300 && n_launch < base + 8; i++) @(negedge clk);
    wait_tx_quiet();
    wait_cycles(20);
    checks++;
    if (n_launch !== base + 8) begin failures++; $display("FAIL tx_ovf_count got=%0d exp=8", n_launch - base); end
    for (int i = 0; i < 8; i++) begin
      if (base + i < n_launch) begin
        checks++;
        if (launch_data[base+i] !== 8'(8'h60 + i)) begin
          failures++; $display("FAIL tx_ovf_order[%0d] got=%h exp=%h", i, launch_data[base+i], 8'(8'h60 + i));
        end
      end
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0046) begin failures++; $display("FAIL tx_ovf_status_end got=%h exp=00000046", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) rx_inject(8'h10 + 8'(i), 1'b1, 1'b0);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_805A) begin failures++; $display("FAIL rx_ovr_status got=%h exp=0000805a", d); end
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'(8'h10 + i)) begin failures++; $display("FAIL rx_ovr_read[%0d] got=%h exp=%h", i, d, 32'(8'h10 + i)); end
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rx_empty_read got=%h exp=00000000", d); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0056) begin failures++; $display("FAIL rx_ovr_status_end got=%h exp=00000056", d); end
  endtask

  task automatic test_irq_sticky();
    logic [31:0] d;
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL ctrl_readback got=%h exp=00000001", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", irq); end
    // Byte and break together: byte is kept and the break flag set.
    rx_inject(8'h55, 1'b1, 1'b1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_before_latency got=%b exp=0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_push got=%b exp=1", irq); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h55) begin failures++; $display("FAIL irq_rx_read got=%h exp=00000055", d); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_pop got=%b exp=0", irq); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0076) begin failures++; $display("FAIL sticky_status got=%h exp=00000076", d); end
    bus_write(2'd3, 32'h10);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0006) begin failures++; $display("FAIL sticky_clear got=%h exp=00000006", d); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL ctrl_after_clear got=%h exp=00000000", d); end
    // TX-empty interrupt source
    bus_write(2'd3, 32'h2);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL tx_irq_latency got=%b exp=0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL tx_irq got=%b exp=1", irq); end
    bus_write(2'd3, 32'h0);
    wait_cycles(2);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b exp=0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    rx_inject(8'h77, 1'b1, 1'b0);
    @(negedge clk);
    bus_addr  = {60'd0, 2'd1, 2'b00};
    bus_wdata = 32'h0;
    bus_wen   = 1'b1;
    bus_ren   = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_wen   = 1'b0;
    bus_ren   = 1'b0;
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL collision_rdata got=%h exp=00000000", d); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_1002) begin failures++; $display("FAIL collision_no_pop got=%h exp=00001002", d); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h77) begin failures++; $display("FAIL collision_rx_read got=%h exp=00000077", d); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int base;
    base = n_launch;
    for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h81 + i);
    for (int i = 0; i < 50 && n_launch == base; i++) @(negedge clk);
    for (int i = 0; i < 50 && !tx_busy; i++) @(negedge clk);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0304) begin failures++; $display("FAIL midframe_queued got=%h exp=00000304", d); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (tx_en !== 1'b0) begin failures++; $display("FAIL midframe_tx_en got=%b exp=0", tx_en); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL midframe_tx_data got=%h exp=00", tx_data); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0006) begin failures++; $display("FAIL midframe_status got=%h exp=00000006", d); end
    wait_cycles(40);
    checks++;
    if (n_launch !== base + 1) begin failures++; $display("FAIL midframe_no_launch got=%0d exp=1", n_launch - base); end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wen   = 1'b0;
    bus_ren   = 1'b0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    rx_break  = 1'b0;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_overrun();
    test_irq_sticky();
    test_collision();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped controller between the CPU data bus and the UART transmitter/receiver pair.
- Buffers CPU writes in a TX FIFO and sequences them into the transmitter one byte at a time using its busy handshake.
- Captures received bytes in an RX FIFO and exposes status/control registers and a level interrupt.
- Replaces direct CPU-to-UART wiring, so the CPU never drops bytes while the transmitter is busy.

Parameters:
- PAYLOAD_BITS, 8, UART data width.
- TX_DEPTH, 8, TX FIFO entries; power of 2, range 2..8.
- RX_DEPTH, 8, RX FIFO entries; power of 2, range 2..8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- bus_addr  in  64  byte address; only [3:2] decoded, upstream decoder qualifies the region
- bus_wdata  in  32  write data
- bus_wen  in  1  write strobe, one cycle per access
- bus_ren  in  1  read strobe, one cycle per access
- bus_rdata  out  32  combinational read data
- tx_data  out  PAYLOAD_BITS  byte to transmitter
- tx_en  out  1  transmitter start pulse
- tx_busy  in  1  transmitter busy
- rx_data  in  PAYLOAD_BITS  received byte
- rx_valid  in  1  received byte valid, one-cycle pulse
- rx_break  in  1  break detected, pulse
- irq  out  1  registered level interrupt

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Both FIFOs flushed; FSM to IDLE.
  - tx_en=0, tx_data=0, irq=0; CTRL enables and sticky flags cleared.
  - Reset mid-frame does not abort a byte already inside the transmitter.
- Register map (bus_addr[3:2]):
  - 0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 1 RXDATA: read returns {24'b0, head} and pops; read when empty returns 0, no pop.
  - 2 STATUS (read-only):
    - b0 tx_full, b1 tx_empty, b2 rx_empty, b3 rx_full
    - b4 rx_overrun (sticky), b5 break_seen (sticky), b6 tx_overflow (sticky)
    - [11:8] tx_count, [15:12] rx_count; other bits 0.
  - 3 CTRL:
    - b0 rx_irq_en, b1 tx_irq_en (read/write).
    - Writing b4=1 clears all three sticky flags; b4 reads 0.
- Bus rules:
  - bus_wen and bus_ren together: write performed, read side effect suppressed, rdata=0.
  - rdata valid in the same cycle as ren; the pop takes effect at that edge.
- TX FIFO:
  - Push when full: byte dropped, tx_overflow set.
  - Push and FSM pop in the same cycle are both honoured; count unchanged.
  - Pointers wrap modulo depth.
- TX FSM:
  - IDLE -> LAUNCH when FIFO non-empty and tx_busy=0.
  - LAUNCH (1 cycle): tx_en=1, tx_data=FIFO head, pop at end of cycle -> WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1 -> WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0 -> IDLE.
  - tx_en is high only in LAUNCH; tx_data holds the last launched byte outside LAUNCH.
  - Minimum spacing between launches is 3 cycles plus the busy duration.
- RX:
  - rx_valid pushes rx_data.
  - If full and no pop that cycle: byte dropped, rx_overrun set.
  - If full and a CPU pop in the same cycle: push accepted, count stays at depth.
  - rx_break sets break_seen and pushes nothing.
  - Simultaneous rx_valid and rx_break: the byte is pushed and the flag set.
- irq: registered, (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty); 1-cycle latency from state change.

Test Plan:
- Reset, then read STATUS -> 0x0000_0006 (tx_empty, rx_empty); tx_en=0; irq=0.
- Write 0x41, 0x42 to TXDATA, with a transmitter model holding busy 10 cycles starting 1 cycle after tx_en -> exactly two single-cycle tx_en pulses with tx_data 0x41 then 0x42; the second pulse occurs only after busy falls; tx_empty set at end.
- Hold tx_busy=1 and write 9 bytes with depth 8 -> tx_full=1, tx_count=8, tx_overflow=1; release busy -> the first 8 bytes are sent in order.
- Inject 9 rx_valid pulses (0x10..0x18) with no reads -> rx_count=8, rx_overrun=1; 8 RXDATA reads return 0x10..0x17; 9th read returns 0.
- Set CTRL=0x1, then inject rx byte 0x55 -> irq high 1 cycle after the push; read RXDATA=0x55 -> irq low the following cycle; write CTRL=0x10 -> sticky flags cleared.
- Assert rst_n=0 while in WAIT_DONE with 3 bytes queued -> next cycle FSM is IDLE, FIFOs empty, tx_en=0, and no further launches occur.
